plru_state_array: RTL and testbench

PLRU_STATE_ARRAY -- requirements
Module: plru_state_array

---
 rtl/plru_state_array_pkg.sv | 34 +++
 rtl/plru_state_array_if.sv | 36 +++
 rtl/plru_state_array_update_victim.sv | 45 ++++
 rtl/plru_state_array.sv | 89 ++++++++
 tb/tb_plru_state_array.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/plru_state_array_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_types (package)
//  Description : Shared cache types: way enum, PLRU state type, reset value
//                and the invalid-way priority helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_types;

    typedef enum logic [1:0] {
        WAY_A = 2'd0,
        WAY_B = 2'd1,
        WAY_C = 2'd2,
        WAY_D = 2'd3
    } way_e;

    typedef logic [2:0] plru_t;

    localparam plru_t PLRU_RESET = 3'b000;

    // Lowest-index way whose valid bit is clear; WAY_A when every line is valid.
    function automatic way_e first_invalid_way(input logic [3:0] mask);
        way_e w;
        w = WAY_A;
        for (int i = 3; i >= 0; i--) begin
            if (!mask[i]) begin
                w = way_e'(i[1:0]);
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/plru_state_array_if.sv
`default_nettype none
// ============================================================================
//  Module      : plru_state_array_if
//  Description : Lookup, update, flush and response signals of the PLRU array.
//  Revision    : 1.0 - initial release
// ============================================================================
interface plru_state_array_if #(
    parameter int SET_W = 4
);
    import cache_types::*;

    logic             flush;
    logic             lkp_valid;
    logic [SET_W-1:0] lkp_set;
    logic [3:0]       lkp_valid_mask;
    logic             upd_valid;
    logic [SET_W-1:0] upd_set;
    logic [1:0]       upd_way;
    logic             rsp_valid;
    logic [1:0]       rsp_victim;
    plru_t            rsp_plru;

    modport master (
        output flush, lkp_valid, lkp_set, lkp_valid_mask,
        output upd_valid, upd_set, upd_way,
        input  rsp_valid, rsp_victim, rsp_plru
    );

    modport slave (
        input  flush, lkp_valid, lkp_set, lkp_valid_mask,
        input  upd_valid, upd_set, upd_way,
        output rsp_valid, rsp_victim, rsp_plru
    );

endinterface
`default_nettype wire

// File: rtl/plru_state_array_update_victim.sv
`default_nettype none
// ============================================================================
//  Module      : plru_update_victim
//  Description : Combinational 4-way tree-PLRU next state and tree victim of
//                the resulting state.
//  Revision    : 1.0 - initial release
// ============================================================================
module plru_update_victim
    import cache_types::*;
(
    input  plru_t i_cur_state,
    input  logic  i_upd_en,
    input  way_e  i_upd_way,
    output plru_t o_next_state,
    output way_e  o_victim
);

    plru_t w_next;

    always_comb begin
        w_next = i_cur_state;
        if (i_upd_en) begin
            case (i_upd_way)
                WAY_A: begin w_next[0] = 1'b0; w_next[1] = 1'b0; end
                WAY_B: begin w_next[0] = 1'b0; w_next[1] = 1'b1; end
                WAY_C: begin w_next[0] = 1'b1; w_next[2] = 1'b0; end
                default: begin w_next[0] = 1'b1; w_next[2] = 1'b1; end
            endcase
        end
    end

    // Victim comes from the half that was not used last.
    always_comb begin
        o_victim = WAY_A;
        if (!w_next[0]) begin
            o_victim = w_next[2] ? WAY_C : WAY_D;
        end else begin
            o_victim = w_next[1] ? WAY_A : WAY_B;
        end
    end

    assign o_next_state = w_next;

endmodule
`default_nettype wire

// File: rtl/plru_state_array.sv
`default_nettype none
// ============================================================================
//  Module      : plru_state_array
//  Description : Per-set 4-way tree-PLRU state with registered victim lookup,
//                same-set update forwarding and global flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module plru_state_array
    import cache_types::*;
#(
    parameter int NUM_SETS = 16,
    parameter int SET_W    = $clog2(NUM_SETS)
) (
    input  logic                clk,
    input  logic                rst,
    plru_state_array_if.slave   bus
);

    plru_t r_state [NUM_SETS];

    plru_t r_rsp_plru;
    way_e  r_rsp_victim;
    logic  r_rsp_valid;

    plru_t w_upd_cur;
    plru_t w_upd_next;
    way_e  w_upd_victim_unused;

    plru_t w_lkp_base;
    logic  w_fwd;
    plru_t w_lkp_state;
    way_e  w_tree_victim;
    way_e  w_victim;

    assign w_upd_cur = r_state[bus.upd_set];

    plru_update_victim u_upd (
        .i_cur_state  (w_upd_cur),
        .i_upd_en     (bus.upd_valid),
        .i_upd_way    (way_e'(bus.upd_way)),
        .o_next_state (w_upd_next),
        .o_victim     (w_upd_victim_unused)
    );

    // A same-set update is folded into the lookup; flush wins and kills it.
    assign w_lkp_base = bus.flush ? PLRU_RESET : r_state[bus.lkp_set];
    assign w_fwd      = bus.upd_valid && !bus.flush && (bus.upd_set == bus.lkp_set);

    plru_update_victim u_lkp (
        .i_cur_state  (w_lkp_base),
        .i_upd_en     (w_fwd),
        .i_upd_way    (way_e'(bus.upd_way)),
        .o_next_state (w_lkp_state),
        .o_victim     (w_tree_victim)
    );

    assign w_victim = (&bus.lkp_valid_mask) ? w_tree_victim
                                            : first_invalid_way(bus.lkp_valid_mask);

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                r_state[i] <= PLRU_RESET;
            end
        end else if (bus.upd_valid) begin
            r_state[bus.upd_set] <= w_upd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_victim <= WAY_A;
            r_rsp_plru   <= PLRU_RESET;
        end else begin
            r_rsp_valid <= bus.lkp_valid;
            if (bus.lkp_valid) begin
                r_rsp_victim <= w_victim;
                r_rsp_plru   <= w_lkp_state;
            end
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_victim = r_rsp_victim;
    assign bus.rsp_plru   = r_rsp_plru;

endmodule
`default_nettype wire

// File: tb/tb_plru_state_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plru_state_array
//  Description : Vector table plus model-driven random traffic, scoreboarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_plru_state_array;

    typedef struct {
        logic       rst_c;
        logic       flush;
        logic       upd_valid;
        logic [3:0] upd_set;
        logic [1:0] upd_way;
        logic       lkp_valid;
        logic [3:0] lkp_set;
        logic [3:0] mask;
        logic [2:0] exp_plru;
        logic [1:0] exp_victim;
    } vec_t;

    typedef struct {
        logic [2:0] plru;
        logic [1:0] victim;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    exp_t       sb_q[$];
    exp_t       last_rsp;
    logic [2:0] m_state [16];
    vec_t       vecs[$];

    plru_state_array_if #(.SET_W(4)) bus ();

    plru_state_array #(.NUM_SETS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic f, input logic uv,
                                input logic [3:0] us, input logic [1:0] uw,
                                input logic lv, input logic [3:0] ls,
                                input logic [3:0] m, input logic [2:0] ep,
                                input logic [1:0] ev);
        vec_t v;
        v.rst_c = r; v.flush = f; v.upd_valid = uv; v.upd_set = us; v.upd_way = uw;
        v.lkp_valid = lv; v.lkp_set = ls; v.mask = m; v.exp_plru = ep; v.exp_victim = ev;
        return v;
    endfunction

    function automatic logic [2:0] m_upd(input logic [2:0] s, input logic [1:0] w);
        case (w)
            2'd0:    return {s[2], 1'b0, 1'b0};
            2'd1:    return {s[2], 1'b1, 1'b0};
            2'd2:    return {1'b0, s[1], 1'b1};
            default: return {1'b1, s[1], 1'b1};
        endcase
    endfunction

    function automatic logic [1:0] m_victim(input logic [2:0] s, input logic [3:0] m);
        if (m != 4'b1111) begin
            for (int i = 0; i < 4; i++) if (!m[i]) return i[1:0];
        end
        if (!s[0]) return s[2] ? 2'd2 : 2'd3;
        return s[1] ? 2'd0 : 2'd1;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drives one cycle, updates the model, then checks the registered response.
    task automatic cycle(input vec_t v, input bit use_model);
        exp_t       e;
        logic [2:0] ls;
        rst                = v.rst_c;
        bus.flush          = v.flush;
        bus.upd_valid      = v.upd_valid;
        bus.upd_set        = v.upd_set;
        bus.upd_way        = v.upd_way;
        bus.lkp_valid      = v.lkp_valid;
        bus.lkp_set        = v.lkp_set;
        bus.lkp_valid_mask = v.mask;

        ls = m_state[v.lkp_set];
        if (v.flush) ls = 3'b000;
        else if (v.upd_valid && v.upd_set == v.lkp_set) ls = m_upd(ls, v.upd_way);
        if (!v.rst_c && v.lkp_valid) begin
            if (use_model) begin
                e.plru = ls; e.victim = m_victim(ls, v.mask);
            end else begin
                e.plru = v.exp_plru; e.victim = v.exp_victim;
            end
            sb_q.push_back(e);
        end
        if (v.rst_c || v.flush) begin
            for (int i = 0; i < 16; i++) m_state[i] = 3'b000;
        end else if (v.upd_valid) begin
            m_state[v.upd_set] = m_upd(m_state[v.upd_set], v.upd_way);
        end

        @(posedge clk);
        #1;
        if (v.rst_c) begin
            sb_q.delete();
            chk("rst_valid", int'(bus.rsp_valid), 0);
            chk("rst_plru", int'(bus.rsp_plru), 0);
            chk("rst_victim", int'(bus.rsp_victim), 0);
            last_rsp.plru = 3'b000; last_rsp.victim = 2'd0;
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("rsp_valid", int'(bus.rsp_valid), 1);
            chk("rsp_plru", int'(bus.rsp_plru), int'(e.plru));
            chk("rsp_victim", int'(bus.rsp_victim), int'(e.victim));
            last_rsp = e;
        end else begin
            chk("idle_valid", int'(bus.rsp_valid), 0);
            chk("hold_plru", int'(bus.rsp_plru), int'(last_rsp.plru));
            chk("hold_victim", int'(bus.rsp_victim), int'(last_rsp.victim));
        end
    endtask

    initial begin
        vec_t v;
        total = 0;
        bad   = 0;
        last_rsp.plru = 3'b000; last_rsp.victim = 2'd0;
        for (int i = 0; i < 16; i++) m_state[i] = 3'b000;
        rst = 1'b1;
        bus.flush = 1'b0; bus.upd_valid = 1'b0; bus.upd_set = '0; bus.upd_way = '0;
        bus.lkp_valid = 1'b0; bus.lkp_set = '0; bus.lkp_valid_mask = 4'hF;
        repeat (2) @(posedge clk);
        #1;

        //         rst flush uv  us    uw  lv  ls    mask   plru    vic
        vecs.push_back(mk(1, 0, 0, 4'd0, 0, 0, 4'd0, 4'hF, 3'b000, 2'd0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 1, 4'd5, 4'hF, 3'b000, 2'd3));
        vecs.push_back(mk(0, 0, 1, 4'd5, 3, 0, 4'd0, 4'hF, 3'b000, 2'd0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 1, 4'd5, 4'hF, 3'b101, 2'd1));
        vecs.push_back(mk(0, 0, 1, 4'd2, 0, 0, 4'd0, 4'hF, 3'b000, 2'd0));
        vecs.push_back(mk(0, 0, 1, 4'd2, 1, 0, 4'd0, 4'hF, 3'b000, 2'd0));
        vecs.push_back(mk(0, 0, 1, 4'd2, 2, 0, 4'd0, 4'hF, 3'b000, 2'd0));
        vecs.push_back(mk(0, 0, 1, 4'd2, 3, 0, 4'd0, 4'hF, 3'b000, 2'd0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 1, 4'd2, 4'hF, 3'b111, 2'd0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 1, 4'd2, 4'hB, 3'b111, 2'd2));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 1, 4'd5, 4'h0, 3'b101, 2'd0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 0, 4'd0, 4'hF, 3'b000, 2'd0));
        vecs.push_back(mk(0, 0, 1, 4'd7, 3, 0, 4'd0, 4'hF, 3'b000, 2'd0));
        vecs.push_back(mk(0, 0, 1, 4'd7, 1, 1, 4'd7, 4'hF, 3'b110, 2'd2));
        vecs.push_back(mk(0, 1, 1, 4'd7, 3, 1, 4'd7, 4'hF, 3'b000, 2'd3));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 1, 4'd7, 4'hF, 3'b000, 2'd3));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 1, 4'd5, 4'hF, 3'b000, 2'd3));
        vecs.push_back(mk(0, 0, 1, 4'd3, 2, 1, 4'd4, 4'hF, 3'b000, 2'd3));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 1, 4'd3, 4'hF, 3'b001, 2'd1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 1, 4'd3, 4'hE, 3'b001, 2'd0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 1, 4'd3, 4'hD, 3'b001, 2'd1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 0, 4'd0, 4'hF, 3'b000, 2'd0));
        foreach (vecs[i]) cycle(vecs[i], 1'b0);

        // Reset coinciding with a lookup and with an update.
        cycle(mk(0, 0, 1, 4'd9, 3, 0, 4'd0, 4'hF, 3'b000, 2'd0), 1'b0);
        cycle(mk(0, 0, 0, 4'd0, 0, 1, 4'd9, 4'hF, 3'b101, 2'd1), 1'b0);
        cycle(mk(1, 0, 1, 4'd4, 1, 1, 4'd9, 4'hF, 3'b000, 2'd0), 1'b0);
        cycle(mk(0, 0, 0, 4'd0, 0, 1, 4'd9, 4'hF, 3'b000, 2'd3), 1'b0);
        cycle(mk(0, 0, 0, 4'd0, 0, 1, 4'd4, 4'hF, 3'b000, 2'd3), 1'b0);

        for (int n = 0; n < 300; n++) begin
            v = mk(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)),
                   ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
                   3'b000, 2'd0);
            if ($urandom_range(0, 3) == 0) v.lkp_set = v.upd_set;
            cycle(v, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
